// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: sequences an external SIPO shift register through one
// frame (clear, WIDTH shifts, capture), hands the captured word to a
// valid/ready consumer, counts accepted words and flags lost start requests.
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] sipo_q,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic             sipo_clr,
    output logic             shift_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic [CNTW-1:0]  frame_cnt
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t        state;
    logic [BW-1:0] bit_cnt;

    // Frame FSM; every strobe is a flop loaded together with the state it
    // belongs to, so no output has a combinational path from an input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sipo_clr  <= 1'b0;
            shift_en  <= 1'b0;
            data_out  <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            sipo_clr <= 1'b0;
            shift_en <= 1'b0;

            // Start seen outside IDLE is lost; a set on the same edge as a clear wins.
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLR;
                        sipo_clr <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                CLR: begin
                    state    <= SHIFT;
                    shift_en <= 1'b1;
                    bit_cnt  <= '0;
                end
                SHIFT: begin
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        state   <= LATCH;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt  <= bit_cnt + BW'(1);
                        shift_en <= 1'b1;
                    end
                end
                LATCH: begin
                    state    <= HOLD;
                    data_out <= sipo_q;
                    valid    <= 1'b1;
                end
                HOLD: begin
                    if (ready) begin
                        state     <= IDLE;
                        valid     <= 1'b0;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + CNTW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
